// File: rtl/icache_fill.sv
// Direct-mapped 32-line x 8-word instruction cache with a blocking line-fill
// controller. Hits return combinationally; a miss stalls fetch until all 8 words land.
module icache_fill #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic [15:0] fetch_instr,
  output logic        fetch_stall,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic [15:0] miss_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]  state_r;
  logic [6:0]  tag_mem_r [0:31];
  logic [15:0] data_mem_r [0:255];
  logic [31:0] valid_r;
  logic [6:0]  fill_tag_r;
  logic [4:0]  fill_index_r;
  logic [3:0]  ic_r;
  logic [2:0]  rc_r;
  logic [15:0] miss_count_r;
  logic [15:0] mem_addr_r;
  logic        mem_rd_r;

  logic [6:0]  req_tag_s;
  logic [4:0]  req_index_s;
  logic [2:0]  req_off_s;
  logic        hit_s;
  logic        miss_s;
  logic        stall_s;
  logic [15:0] instr_s;
  logic        unused_s;

  assign req_tag_s   = fetch_addr[15:9];
  assign req_index_s = fetch_addr[8:4];
  assign req_off_s   = fetch_addr[3:1];
  assign unused_s    = fetch_addr[0];

  // Lookup, stall and instruction return
  always_comb begin
    hit_s   = 1'b0;
    miss_s  = 1'b0;
    stall_s = 1'b0;
    instr_s = 16'h0000;
    case (state_r)
      ST_IDLE: begin
        hit_s = valid_r[req_index_s] && (tag_mem_r[req_index_s] == req_tag_s);
        if (fetch_req && !hit_s) begin
          miss_s  = 1'b1;
          stall_s = 1'b1;
        end else if (fetch_req) begin
          instr_s = data_mem_r[{req_index_s, req_off_s}];
        end else begin
          instr_s = 16'h0000;
        end
      end
      ST_FILL: stall_s = 1'b1;
      default: stall_s = 1'b1;
    endcase
  end

  // Fill FSM: ic_r counts reads already issued, rc_r counts words returned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      valid_r      <= 32'h0000_0000;
      fill_tag_r   <= 7'd0;
      fill_index_r <= 5'd0;
      ic_r         <= 4'd0;
      rc_r         <= 3'd0;
      miss_count_r <= 16'h0000;
      mem_addr_r   <= 16'h0000;
      mem_rd_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_s) begin
            state_r              <= ST_FILL;
            fill_tag_r           <= req_tag_s;
            fill_index_r         <= req_index_s;
            valid_r[req_index_s] <= 1'b0;
            miss_count_r         <= miss_count_r + 16'd1;
            ic_r                 <= 4'd1;
            rc_r                 <= 3'd0;
            mem_rd_r             <= 1'b1;
            mem_addr_r           <= {req_tag_s, req_index_s, 3'd0, 1'b0};
          end else begin
            mem_rd_r <= 1'b0;
          end
        end
        ST_FILL: begin
          if (!ic_r[3]) begin
            mem_rd_r   <= 1'b1;
            mem_addr_r <= {fill_tag_r, fill_index_r, ic_r[2:0], 1'b0};
            ic_r       <= ic_r + 4'd1;
          end else begin
            mem_rd_r <= 1'b0;
          end
          if (mem_valid) begin
            rc_r <= rc_r + 3'd1;
            if (rc_r == 3'd7) begin
              valid_r[fill_index_r] <= 1'b1;
              state_r               <= ST_IDLE;
              ic_r                  <= 4'd0;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Tag/data arrays are not reset; writes only happen while filling
  always_ff @(posedge clk) begin
    if (state_r == ST_FILL && mem_valid) begin
      data_mem_r[{fill_index_r, rc_r}] <= mem_data;
      if (rc_r == 3'd7) begin
        tag_mem_r[fill_index_r] <= fill_tag_r;
      end
    end
  end

  assign fetch_instr = instr_s;
  assign fetch_stall = stall_s;
  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign miss_count  = miss_count_r;

endmodule

// File: doc/icache_fill.md
# icache_fill

Direct-mapped instruction cache and fill controller answering the fetch stage's instruction reads. Fetch presents a PC every cycle. On a hit the block returns the instruction combinationally; on a miss it stalls fetch and refills an 8-word block from the multi-cycle backing memory. It replaces the single-cycle instruction memory on the fetch path.

## Interface

Parameters:
- MEM_LAT, 4, backing memory read latency in cycles from mem_rd to mem_valid (informational; the block counts returns and does not time them)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- fetch_req  in  1  fetch wants an instruction this cycle
- fetch_addr  in  16  byte address (PC); bit 0 ignored
- fetch_instr  out  16  instruction word; valid when fetch_stall=0 and fetch_req=1
- fetch_stall  out  1  fetch must hold PC and treat fetch_instr as invalid
- mem_rd  out  1  one-cycle word read strobe to backing memory
- mem_addr  out  16  word-aligned byte address for mem_rd
- mem_data  in  16  returned word
- mem_valid  in  1  mem_data valid; returns arrive in issue order
- miss_count  out  16  number of misses taken, wraps at 16'hFFFF -> 0

## Operation

- Geometry: 32 lines × 8 words × 16 bits. tag = addr[15:9] (7b), index = addr[8:4] (5b), word offset = addr[3:1]. Per line: 7-bit tag plus valid bit.
- Hit: fetch_req=1, state IDLE, valid[index]=1 and tag match. fetch_instr = data[index][offset], fetch_stall=0.
- Miss: fetch_req=1, state IDLE, not hit.
  - fetch_stall=1.
  - Latch fill_tag and fill_index from fetch_addr.
  - Increment miss_count.
  - Next state FILL.
- FILL:
  - issue counter ic (0..7) and receive counter rc (0..7), both cleared on entry.
  - While ic<8: mem_rd=1, mem_addr={fill_tag, fill_index, ic[2:0], 1'b0}, ic++ every cycle. No gaps: 8 reads on 8 consecutive cycles.
  - On each mem_valid: data[fill_index][rc] <= mem_data, rc++.
  - On the 8th mem_valid: tag[fill_index] <= fill_tag, valid[fill_index] <= 1, next state IDLE.
  - valid[fill_index] is cleared on FILL entry, so a partially filled line never hits.
- fetch_stall=1 for the entire FILL state regardless of fetch_addr or fetch_req.
- fetch_addr changing during FILL (redirect): the fill always completes. The new address is evaluated in IDLE afterwards and may miss again.
- fetch_req=0 in IDLE: no miss, fetch_stall=0, fetch_instr=16'h0000, miss_count unchanged.
- Any cycle with fetch_stall=1 drives fetch_instr=16'h0000.
- mem_valid while in IDLE is ignored; no array writes.
- mem_rd=0 and mem_addr holds its last value whenever not issuing.

## Timing

- Reset (rst=0, async):
  - state=IDLE, all valid bits=0, ic=rc=0, miss_count=0, mem_rd=0, mem_addr=0.
  - Tag and data arrays are not reset.
  - Outputs after reset: fetch_stall = fetch_req (cold miss), fetch_instr=0.
- Reset mid-fill: the fill is abandoned and the line stays invalid. Late mem_valid returns after reset are ignored, because the block is in IDLE.
- Hit latency: 0 cycles (combinational from fetch_addr).
- Miss timeline with MEM_LAT=4, miss detected in cycle 0:
  - mem_rd asserted in cycles 1–8.
  - mem_valid in cycles 5–12.
  - line valid at the edge ending cycle 12.
  - cycle 13: IDLE, hit, fetch_stall=0.
  - Penalty: 13 stall cycles.
- General miss penalty: 9 + MEM_LAT stall cycles.
- Single array write port. The fill write and the fetch read never coincide on a usable result, because fetch is stalled during FILL.
- miss_count increments on the edge ending the miss-detect cycle.

## Test plan

- Cold miss: release reset, fetch_req=1, fetch_addr=16'h0000. Memory model returns word = addr ^ 16'hA5A5.
  - Required: mem_rd high for exactly 8 cycles, mem_addr 0x0000..0x000E in order.
  - fetch_stall high for 13 cycles, then fetch_instr=16'hA5A5.
  - miss_count=1.
- Spatial hits: after the cold fill, sweep fetch_addr 0x0002..0x000E one per cycle.
  - Required: fetch_stall=0 every cycle, fetch_instr = addr^16'hA5A5, no mem_rd, miss_count stays 1.
- Conflict eviction: fetch 0x0200 (same index 0, tag 1), then 0x0000.
  - Required: both miss, miss_count=3.
  - 0x0200 returns 16'hA7A5; 0x0000 refills and returns 16'hA5A5.
- Redirect mid-fill: miss on 0x0010, then change fetch_addr to 0x0002 in fill cycle 3.
  - Required: all 8 reads still issue for 0x0010–0x001E.
  - After the fill, 0x0002 hits if line 0 is valid, with no extra mem_rd.
- Reset mid-fill: assert rst=0 during fill cycle 6, release, then present the same address.
  - Required: outputs return to reset values immediately.
  - Stray mem_valid pulses cause no writes.
  - A full 8-read refill occurs and miss_count restarts from 0→1.
- fetch_req=0: hold fetch_req=0 with a non-resident address for 10 cycles.
  - Required: fetch_stall=0, fetch_instr=0, no mem_rd, miss_count unchanged.
